// File: rtl/imem_fetch_ctrl_if.sv
// imem_fetch_ctrl_if: memory, redirect and decode-side handshake signals of the fetch controller
interface imem_fetch_ctrl_if;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  modport master (
    input  fetch_en, redirect_valid, redirect_pc, imem_rdata, out_ready,
    output imem_addr, out_valid, out_instr, out_pc, fault
  );
  modport slave (
    output fetch_en, redirect_valid, redirect_pc, imem_rdata, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc, fault
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: fetch PC sequencer with redirect/halt and a small instruction queue toward decode
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DEPTH      = 2,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  imem_fetch_ctrl_if.master  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t          state;
  logic [31:0]     fpc;
  logic [CW-1:0]   count;
  logic [AW-1:0]   wptr, rptr;
  logic            flt;
  logic [31:0]     q_instr [DEPTH];
  logic [31:0]     q_pc    [DEPTH];
  logic [31:0]     tgt;
  logic            pop, push, room, fpc_ok, tgt_ok;
  function automatic logic in_range(input logic [31:0] a);
    return (a >> 2) < 32'(IMEM_WORDS);
  endfunction
  assign tgt           = bus.redirect_pc & ~32'h3;
  assign fpc_ok        = in_range(fpc);
  assign tgt_ok        = in_range(tgt);
  assign bus.out_valid = (count != '0) & ~bus.redirect_valid;
  assign pop           = bus.out_valid & bus.out_ready;
  assign room          = (count < CW'(DEPTH)) | pop;
  assign push          = (state == RUN) & bus.fetch_en & ~bus.redirect_valid & fpc_ok & room;
  assign bus.imem_addr = fpc;
  assign bus.out_instr = q_instr[rptr];
  assign bus.out_pc    = q_pc[rptr];
  assign bus.fault     = flt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      fpc   <= RESET_PC;
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
      flt   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (bus.redirect_valid) begin
      fpc   <= tgt;
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
      state <= (state == HALT && !tgt_ok) ? HALT : RUN;
      flt   <= (state == HALT) ? ~tgt_ok : flt;
    end else begin
      if (state == BOOT) begin
        state <= fpc_ok ? RUN : HALT;
        flt   <= ~fpc_ok;
      end else if (state == RUN && bus.fetch_en && room && !fpc_ok) begin
        state <= HALT;
        flt   <= 1'b1;
      end
      if (push) begin
        q_instr[wptr] <= bus.imem_rdata;
        q_pc[wptr]    <= fpc;
        wptr          <= wptr + AW'(1);
        fpc           <= fpc + 32'd4;
      end
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: scoreboard bench for imem_fetch_ctrl with a word-indexed 0xA000_0000+i memory
module tb_imem_fetch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  imem_fetch_ctrl_if bus ();
  imem_fetch_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.imem_rdata = 32'hA000_0000 + (bus.imem_addr >> 2);
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb[$];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic [31:0] e;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) check("extra_handshake", 32'(bus.out_valid & bus.out_ready), 0);
      else begin
        e = sb.pop_front();
        check("out_pc", bus.out_pc, e);
        check("out_instr", bus.out_instr, 32'hA000_0000 + (e >> 2));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drain(input int bound);
    bus.out_ready = 1'b1;
    for (int i = 0; i < bound && sb.size() != 0; i++) tick();
    bus.out_ready = 1'b0;
    check("drain_empty", 32'(sb.size()), 0);
  endtask
  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    #1 check("redirect_no_valid", 32'(bus.out_valid), 0);
    tick();
    bus.redirect_valid = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    bus.fetch_en = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    #1;
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_addr", bus.imem_addr, 0);
    check("rst_fault", 32'(bus.fault), 0);
    check("rst_pc", bus.out_pc, 0);
    check("rst_instr", bus.out_instr, 0);
    // 1: stream from reset, one instruction per cycle after the boot cycle
    for (int i = 0; i < 8; i++) sb.push_back(32'(i * 4));
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    tick();
    check("t1_first_valid", 32'(bus.out_valid), 1);
    check("t1_first_pc", bus.out_pc, 0);
    repeat (8) tick();
    check("t1_throughput", 32'(sb.size()), 0);
    bus.out_ready = 1'b0;
    // 2: stall from reset, queue fills and fetch PC stalls
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) tick();
    check("t2_valid", 32'(bus.out_valid), 1);
    check("t2_pc", bus.out_pc, 0);
    check("t2_instr", bus.out_instr, 32'hA000_0000);
    check("t2_addr", bus.imem_addr, 32'h8);
    for (int i = 0; i < 4; i++) sb.push_back(32'(i * 4));
    drain(10);
    // 3: redirect with a full queue flushes old entries
    repeat (3) tick();
    check("t3_full_valid", 32'(bus.out_valid), 1);
    sb.delete();
    sb.push_back(32'h100);
    sb.push_back(32'h104);
    sb.push_back(32'h108);
    redirect(32'h103);
    check("t3_addr", bus.imem_addr, 32'h100);
    check("t3_gap_valid", 32'(bus.out_valid), 0);
    tick();
    check("t3_target_valid", 32'(bus.out_valid), 1);
    check("t3_target_pc", bus.out_pc, 32'h100);
    drain(8);
    // 4: last in-range word, then halt and recover
    sb.delete();
    sb.push_back(32'hFFC);
    redirect(32'hFFC);
    drain(6);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    check("t4_fault", 32'(bus.fault), 1);
    check("t4_valid", 32'(bus.out_valid), 0);
    check("t4_addr", bus.imem_addr, 32'h1000);
    bus.out_ready = 1'b0;
    sb.push_back(32'h40);
    sb.push_back(32'h44);
    redirect(32'h40);
    check("t4_fault_clr", 32'(bus.fault), 0);
    drain(8);
    // 5: fetch disabled drains queue, then asynchronous reset mid-cycle
    sb.delete();
    sb.push_back(32'h200);
    redirect(32'h200);
    tick();
    bus.fetch_en = 1'b0;
    check("t5_addr", bus.imem_addr, 32'h204);
    drain(4);
    bus.out_ready = 1'b1;
    repeat (2) tick();
    check("t5_empty", 32'(bus.out_valid), 0);
    check("t5_addr_hold", bus.imem_addr, 32'h204);
    bus.out_ready = 1'b0;
    bus.fetch_en = 1'b1;
    repeat (3) tick();
    check("t5_refill", 32'(bus.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_arst_valid", 32'(bus.out_valid), 0);
    check("t5_arst_addr", bus.imem_addr, 0);
    check("t5_arst_pc", bus.out_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // 6: redirect while head valid and decode ready
    repeat (4) tick();
    check("t6_head_valid", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    sb.push_back(32'h80);
    sb.push_back(32'h84);
    redirect(32'h80);
    drain(8);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
